// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: the state enum,
// the default widths and the branch-target table.
// Ports: none (package).
package pc_sequencer_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int LUT_W_DEF = 4;

  // The table is sized for the default index width; other LUT_W values are
  // folded onto it by the lookup.
  localparam int TBL_IDX_W = LUT_W_DEF;
  localparam int TBL_DEPTH = 1 << TBL_IDX_W;

  // Entries are stored 16 bits wide and truncated to PC_W at lookup.
  localparam logic [15:0] TARGET_TABLE [TBL_DEPTH] = '{
    16'd12,  16'd40,  16'd100, 16'd200,
    16'd7,   16'd300, 16'd511, 16'd1023,
    16'd0,   16'd64,  16'd128, 16'd256,
    16'd513, 16'd700, 16'd900, 16'd1000
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the instruction decoder/ALU and the sequencer.
// Ports: decoder/ALU inputs (START..SC_WE) and sequencer status (SC_IN, PC,
// RUNNING, DONE). No handshake: signals are sampled every clock.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int LUT_W = LUT_W_DEF
);
  logic             START;
  logic             HALT;
  logic             JUMP;
  logic             BRANCH;
  logic             BR_FLAG;
  logic [LUT_W-1:0] TARGET_SEL;
  logic             SC_OUT;
  logic             SC_WE;
  logic             SC_IN;
  logic [PC_W-1:0]  PC;
  logic             RUNNING;
  logic             DONE;

  // Driver side: the decoder/ALU (or a testbench).
  modport master (
    output START, HALT, JUMP, BRANCH, BR_FLAG, TARGET_SEL, SC_OUT, SC_WE,
    input  SC_IN, PC, RUNNING, DONE
  );

  // Sequencer side.
  modport slave (
    input  START, HALT, JUMP, BRANCH, BR_FLAG, TARGET_SEL, SC_OUT, SC_WE,
    output SC_IN, PC, RUNNING, DONE
  );
endinterface

// File: rtl/pc_sequencer_branch_lut.sv
// Branch-target lookup: maps TARGET_SEL onto the constant target table.
// Latency: purely combinational, zero cycles.
// Ports: TARGET_SEL in, target (PC_W) out; no backpressure.
module branch_lut
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int LUT_W = LUT_W_DEF
) (
  input  logic [LUT_W-1:0] TARGET_SEL,
  output logic [PC_W-1:0]  target
);

  logic [TBL_IDX_W-1:0] idx;

  // Resize the selector to the table's index width (truncate or zero-extend).
  assign idx    = TBL_IDX_W'(TARGET_SEL);
  assign target = PC_W'(TARGET_TABLE[idx]);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALTED FSM with jump/branch targets
// and a one-bit shift/carry feedback register.
// Latency: PC, SC_IN, RUNNING, DONE all registered, one cycle after inputs.
// Ports: CLK, RESET (sync, active-high), bus (slave modport); no backpressure.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int LUT_W = LUT_W_DEF
) (
  input  logic           CLK,
  input  logic           RESET,
  pc_sequencer_if.slave  bus
);

  seq_state_t      state;
  logic [PC_W-1:0] pc_q;
  logic            sc_q;
  logic            running_q;
  logic            done_q;
  logic [PC_W-1:0] target;

  branch_lut #(
    .PC_W  (PC_W),
    .LUT_W (LUT_W)
  ) u_lut (
    .TARGET_SEL (bus.TARGET_SEL),
    .target     (target)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      pc_q      <= '0;
      sc_q      <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        // IDLE and HALTED both wait for START; a restart always begins at 0
        // with the carry cleared. PC/DONE simply hold otherwise.
        ST_IDLE, ST_HALTED: begin
          if (bus.START) begin
            state     <= ST_RUN;
            pc_q      <= '0;
            sc_q      <= 1'b0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end

        ST_RUN: begin
          if (bus.HALT) begin
            state     <= ST_HALTED;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (bus.JUMP || (bus.BRANCH && bus.BR_FLAG)) begin
            pc_q <= target;
          end else begin
            pc_q <= pc_q + PC_W'(1);  // wraps naturally at 2**PC_W
          end
          // Carry capture is independent of the PC decision.
          if (bus.SC_WE) begin
            sc_q <= bus.SC_OUT;
          end
        end

        default: begin
          state     <= ST_IDLE;
          pc_q      <= '0;
          sc_q      <= 1'b0;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC      = pc_q;
  assign bus.SC_IN   = sc_q;
  assign bus.RUNNING = running_q;
  assign bus.DONE    = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vectors, a behavioural reference model
// and a per-cycle comparison against it.
module tb_pc_sequencer;

  localparam int PC_W  = 10;
  localparam int LUT_W = 4;
  localparam int PC_MOD = 1 << PC_W;

  logic CLK;
  logic RESET;

  pc_sequencer_if #(.PC_W(PC_W), .LUT_W(LUT_W)) bus ();

  pc_sequencer #(.PC_W(PC_W), .LUT_W(LUT_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Independent copy of the expected target table.
  int tbl [16] = '{12, 40, 100, 200, 7, 300, 511, 1023,
                   0, 64, 128, 256, 513, 700, 900, 1000};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = idle, 1 = running, 2 = halted.
  int m_mode  = 0;
  int m_pc    = 0;
  int m_sc    = 0;
  bit m_valid = 1'b0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_mode  <= 0;
      m_pc    <= 0;
      m_sc    <= 0;
      m_valid <= 1'b1;
    end else if (m_mode == 1) begin
      if (bus.HALT) m_mode <= 2;
      else if (bus.JUMP || (bus.BRANCH && bus.BR_FLAG)) m_pc <= tbl[int'(bus.TARGET_SEL)];
      else m_pc <= (m_pc + 1) % PC_MOD;
      if (bus.SC_WE) m_sc <= int'(bus.SC_OUT);
    end else if (bus.START) begin
      m_mode <= 1;
      m_pc   <= 0;
      m_sc   <= 0;
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge CLK) begin
    if (m_valid) begin
      check("model_pc",      int'(bus.PC),      m_pc);
      check("model_sc_in",   int'(bus.SC_IN),   m_sc);
      check("model_running", int'(bus.RUNNING), (m_mode == 1) ? 1 : 0);
      check("model_done",    int'(bus.DONE),    (m_mode == 2) ? 1 : 0);
    end
  end

  task automatic clr_in();
    bus.START = 0; bus.HALT = 0; bus.JUMP = 0; bus.BRANCH = 0;
    bus.BR_FLAG = 0; bus.TARGET_SEL = '0; bus.SC_OUT = 0; bus.SC_WE = 0;
  endtask

  // Inputs set before this call are sampled at the rising edge inside it.
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  // Halt (if running), restart, then advance n sequential steps.
  task automatic restart_to(input int n);
    clr_in(); bus.HALT = 1; cyc();
    clr_in(); bus.START = 1; cyc();
    clr_in(); cyc(n);
  endtask

  initial begin
    clr_in();
    RESET = 1'b1;
    cyc(2);
    check("reset_pc",      int'(bus.PC), 0);
    check("reset_running", int'(bus.RUNNING), 0);
    check("reset_done",    int'(bus.DONE), 0);
    check("reset_sc",      int'(bus.SC_IN), 0);

    // IDLE ignores control inputs other than START.
    RESET = 1'b0;
    bus.HALT = 1; bus.JUMP = 1; bus.TARGET_SEL = 4'd3; bus.SC_WE = 1; bus.SC_OUT = 1;
    cyc(2);
    check("idle_pc_hold", int'(bus.PC), 0);
    check("idle_sc_hold", int'(bus.SC_IN), 0);

    // START, then five plain steps.
    clr_in(); bus.START = 1; cyc();
    check("start_pc", int'(bus.PC), 0);
    check("start_running", int'(bus.RUNNING), 1);
    clr_in(); cyc(5);
    check("seq_pc5", int'(bus.PC), 5);
    check("seq_done", int'(bus.DONE), 0);

    // START in RUN is ignored.
    bus.START = 1; cyc();
    check("start_in_run", int'(bus.PC), 6);

    // Taken and not-taken branch at PC=3.
    restart_to(3);
    check("pc_at3", int'(bus.PC), 3);
    bus.BRANCH = 1; bus.BR_FLAG = 1; bus.TARGET_SEL = 4'd2; cyc();
    check("branch_taken", int'(bus.PC), 100);
    restart_to(3);
    bus.BRANCH = 1; bus.BR_FLAG = 0; bus.TARGET_SEL = 4'd2; cyc();
    check("branch_not_taken", int'(bus.PC), 4);
    clr_in(); bus.BR_FLAG = 1; bus.TARGET_SEL = 4'd2; cyc();
    check("flag_without_branch", int'(bus.PC), 5);
    clr_in(); bus.JUMP = 1; bus.TARGET_SEL = 4'd5; cyc();
    check("jump", int'(bus.PC), 300);
    clr_in(); bus.JUMP = 1; bus.BRANCH = 1; bus.BR_FLAG = 1; bus.TARGET_SEL = 4'd13; cyc();
    check("jump_branch_both", int'(bus.PC), 700);

    // HALT beats JUMP at PC=7.
    restart_to(7);
    bus.HALT = 1; bus.JUMP = 1; bus.TARGET_SEL = 4'd1; cyc();
    check("halt_pc", int'(bus.PC), 7);
    check("halt_done", int'(bus.DONE), 1);
    check("halt_running", int'(bus.RUNNING), 0);
    clr_in(); bus.JUMP = 1; bus.HALT = 1; cyc(2);
    check("halted_hold_pc", int'(bus.PC), 7);
    clr_in(); bus.START = 1; cyc();
    check("restart_pc", int'(bus.PC), 0);
    check("restart_running", int'(bus.RUNNING), 1);
    check("restart_done", int'(bus.DONE), 0);

    // Wrap from 1023 to 0.
    clr_in(); bus.JUMP = 1; bus.TARGET_SEL = 4'd7; cyc();
    check("pc_max", int'(bus.PC), 1023);
    clr_in(); cyc();
    check("pc_wrap", int'(bus.PC), 0);
    check("wrap_running", int'(bus.RUNNING), 1);

    // Carry register.
    bus.SC_WE = 1; bus.SC_OUT = 1; cyc();
    check("sc_capture1", int'(bus.SC_IN), 1);
    bus.SC_WE = 0; bus.SC_OUT = 0; cyc();
    check("sc_hold", int'(bus.SC_IN), 1);
    bus.SC_WE = 1; bus.SC_OUT = 0; cyc();
    check("sc_capture0", int'(bus.SC_IN), 0);
    bus.SC_WE = 1; bus.SC_OUT = 1; cyc();
    clr_in(); bus.HALT = 1; cyc();
    clr_in(); bus.SC_WE = 1; bus.SC_OUT = 0; cyc();
    check("sc_we_halted_ignored", int'(bus.SC_IN), 1);
    clr_in(); bus.START = 1; cyc();
    check("sc_clear_on_start", int'(bus.SC_IN), 0);

    // Reset mid-run with START also high.
    restart_to(9);
    bus.SC_WE = 1; bus.SC_OUT = 1; cyc();
    check("pc_at10", int'(bus.PC), 10);
    restart_to(9);
    check("pc_at9", int'(bus.PC), 9);
    RESET = 1'b1; bus.START = 1; cyc();
    check("rst_mid_pc", int'(bus.PC), 0);
    check("rst_mid_running", int'(bus.RUNNING), 0);
    check("rst_mid_done", int'(bus.DONE), 0);
    check("rst_mid_sc", int'(bus.SC_IN), 0);
    RESET = 1'b0; clr_in(); cyc(2);
    check("after_rst_idle", int'(bus.PC), 0);

    // Mixed stimulus, checked against the model each cycle.
    bus.START = 1; cyc();
    for (int i = 0; i < 300; i++) begin
      bus.START      = ($urandom_range(0, 15) == 0);
      bus.HALT       = ($urandom_range(0, 31) == 0);
      bus.JUMP       = ($urandom_range(0, 15) == 0);
      bus.BRANCH     = ($urandom_range(0, 7) == 0);
      bus.BR_FLAG    = $urandom_range(0, 1);
      bus.TARGET_SEL = 4'($urandom_range(0, 15));
      bus.SC_OUT     = $urandom_range(0, 1);
      bus.SC_WE      = $urandom_range(0, 1);
      RESET          = ($urandom_range(0, 127) == 0);
      cyc();
    end
    RESET = 1'b0; clr_in(); cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter: PC_W, default 10, program counter width in bits.
REQ-003 Parameter: LUT_W, default 4, branch-target index width (2**LUT_W entries).
REQ-004 Port: CLK  input  1  sole clock, all state updates on rising edge.
REQ-005 Port: RESET  input  1  synchronous active-high reset.
REQ-006 Port: START  input  1  begin program execution from address 0.
REQ-007 Port: HALT  input  1  current instruction is halt.
REQ-008 Port: JUMP  input  1  current instruction is an unconditional jump.
REQ-009 Port: BRANCH  input  1  current instruction is a conditional branch.
REQ-010 Port: BR_FLAG  input  1  ALU branch condition result, sampled with BRANCH.
REQ-011 Port: TARGET_SEL  input  LUT_W  index into branch-target table.
REQ-012 Port: SC_OUT  input  1  shift/carry bit produced by the ALU.
REQ-013 Port: SC_WE  input  1  capture SC_OUT into the carry register.
REQ-014 Port: SC_IN  output  1  registered carry fed back to ALU SC_IN.
REQ-015 Port: PC  output  PC_W  address of current instruction.
REQ-016 Port: RUNNING  output  1  high while in RUN.
REQ-017 Port: DONE  output  1  high while in HALTED.

Function
REQ-018 FSM states SHALL be IDLE, RUN, HALTED; outputs registered, Moore-style.
REQ-019 IDLE: PC held at 0; START=1 -> RUN next edge with PC=0; all other control inputs ignored.
REQ-020 RUN next-PC priority SHALL be HALT > JUMP > (BRANCH & BR_FLAG) > PC+1.
REQ-021 HALT in RUN -> HALTED next edge; PC holds its current value.
REQ-022 JUMP, or BRANCH with BR_FLAG=1 -> PC <= TARGET_TABLE[TARGET_SEL] next edge.
REQ-023 BRANCH with BR_FLAG=0 -> PC <= PC+1; BR_FLAG ignored when BRANCH=0 and JUMP=0.
REQ-024 PC+1 SHALL wrap modulo 2**PC_W (max value -> 0) with no flag and no state change.
REQ-025 HALTED: PC and DONE hold; START=1 -> RUN next edge with PC=0, DONE=0.
REQ-026 START in RUN SHALL be ignored (no restart mid-program).
REQ-027 SC register: in RUN, SC_WE=1 -> SC_IN <= SC_OUT next edge; else holds.
REQ-028 SC register SHALL clear to 0 on the edge that accepts START; SC_WE ignored outside RUN.
REQ-029 Latency: every PC update and SC capture visible exactly one cycle after the sampled inputs.

Reset
REQ-030 RESET=1 at an edge SHALL force state IDLE, PC=0, SC_IN=0, RUNNING=0, DONE=0.
REQ-031 RESET SHALL override all inputs, including START in the same cycle, in any state (mid-run included).

Structure
REQ-032 Shared package SHALL hold the state enum, PC_W/LUT_W defaults and the TARGET_TABLE constant.
REQ-033 Target lookup SHALL be one combinational sub-module, branch_lut (TARGET_SEL in, target address out).

Verification
REQ-034 RESET, then START 1 cycle, 5 idle RUN cycles -> PC 0,1,2,3,4,5; RUNNING=1; DONE=0.
REQ-035 RUN at PC=3, BRANCH=1 BR_FLAG=1 TARGET_SEL=2 -> PC=TARGET_TABLE[2]; repeat with BR_FLAG=0 -> PC=4.
REQ-036 HALT=1 and JUMP=1 together at PC=7 -> HALTED, PC stays 7, DONE=1; START -> PC=0, RUNNING=1, DONE=0.
REQ-037 Run PC to 1023 with PC_W=10 -> next PC=0, still RUN.
REQ-038 SC_WE=1 SC_OUT=1 in RUN -> SC_IN=1 next cycle; SC_WE=0 -> holds; START from HALTED -> SC_IN=0.
REQ-039 RESET asserted at PC=9 in RUN with START=1 -> next cycle IDLE, PC=0, all outputs 0.
